// File: rtl/vga_driver_pkg.sv
// Shared video constants: 640x480@60 timing, palette entries used by the video path,
// and the RRRGGGBB to 24-bit colour expansion.
package vga_driver_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [7:0] TRANSPARENT_COLOR = 8'hE3;
    localparam logic [7:0] BACKGROUND_COLOR  = 8'h7B;
    localparam logic [7:0] COLOR_RED         = 8'hE0;
    localparam logic [7:0] COLOR_YELLOW      = 8'hFC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Bit replication so full-scale 3/2-bit codes map to 8'hFF and zero stays zero.
    function automatic rgb24_t expand_rgb332(input logic [7:0] c);
        rgb24_t o;
        o.r = {c[7:5], c[7:5], c[7:6]};
        o.g = {c[4:2], c[4:2], c[4:3]};
        o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel tick divider (clk/2), horizontal/vertical scan counters and the
// once-per-frame pulse that paces game logic.
module vga_timing_counter #(
    parameter int H_TOTAL = vga_driver_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_driver_pkg::V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    output logic       vga_clk,
    output logic       tick,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Counters advance while vga_clk is high, i.e. on its falling edge, so the
    // DAC sees stable data on the following rising edge.
    assign tick = vga_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_clk     <= 1'b0;
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_clk     <= ~vga_clk;
            frame_start <= 1'b0;
            if (tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    if (v == V_LAST) begin
                        v           <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        v <= v + 10'd1;
                    end
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_driver.sv
// VGA timing generator and output stage: publishes scan coordinates, registers the
// returned RRRGGGBB colour and drives the DAC with RGB888, syncs, blank and pixel clock.
module vga_driver #(
    parameter int H_VISIBLE = vga_driver_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_driver_pkg::H_FRONT,
    parameter int H_SYNC    = vga_driver_pkg::H_SYNC,
    parameter int H_BACK    = vga_driver_pkg::H_BACK,
    parameter int V_VISIBLE = vga_driver_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_driver_pkg::V_FRONT,
    parameter int V_SYNC    = vga_driver_pkg::V_SYNC,
    parameter int V_BACK    = vga_driver_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] color_in,
    output logic [9:0] current_pixel_x,
    output logic [9:0] current_pixel_y,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_start
);

    import vga_driver_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       tick;
    logic [9:0] h;
    logic [9:0] v;

    vga_timing_counter #(
        .H_TOTAL (H_TOT),
        .V_TOTAL (V_TOT)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .vga_clk     (vga_clk),
        .tick        (tick),
        .h           (h),
        .v           (v),
        .frame_start (frame_start)
    );

    assign current_pixel_x = h;
    assign current_pixel_y = v;
    assign vga_sync_n      = 1'b0;

    // Stage p0: decode the current scan position and expand the upstream colour.
    logic   visible_p0;
    logic   hsync_n_p0;
    logic   vsync_n_p0;
    rgb24_t rgb_p0;

    always_comb begin
        visible_p0 = (h < H_VIS_END) && (v < V_VIS_END);
        hsync_n_p0 = !((h >= HS_START) && (h < HS_END));
        vsync_n_p0 = !((v >= VS_START) && (v < VS_END));
        rgb_p0     = '0;
        if (visible_p0) begin
            rgb_p0 = expand_rgb332(color_in);
        end
    end

    // Stage p1: single shared register so syncs, blank and RGB stay mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (tick) begin
            vga_hsync   <= hsync_n_p0;
            vga_vsync   <= vsync_n_p0;
            vga_blank_n <= visible_p0;
            vga_r       <= rgb_p0.r;
            vga_g       <= rgb_p0.g;
            vga_b       <= rgb_p0.b;
        end
    end

endmodule

// File: tb/tb_vga_driver.sv
// Directed bench for vga_driver on a shrunken raster (15x8 total, 8x4 visible) so
// whole frames fit in a short run; expected values are worked out by hand.
module tb_vga_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] color_in = 8'h00;
    logic [9:0] current_pixel_x;
    logic [9:0] current_pixel_y;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       vga_clk;
    logic       frame_start;

    // H: visible 0..7, front 8..9, sync 10..12, back 13..14. V: visible 0..3, front 4, sync 5..6, back 7.
    vga_driver #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .color_in        (color_in),
        .current_pixel_x (current_pixel_x),
        .current_pixel_y (current_pixel_y),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_hsync       (vga_hsync),
        .vga_vsync       (vga_vsync),
        .vga_blank_n     (vga_blank_n),
        .vga_sync_n      (vga_sync_n),
        .vga_clk         (vga_clk),
        .frame_start     (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int fs_seen  = 0;

    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y);
        int k;
        k = 0;
        while (!(current_pixel_x == 10'(x) && current_pixel_y == 10'(y)) && k < 2000) begin
            cyc(1);
            k++;
        end
        n_checks++;
        assert (k < 2000) else begin
            n_fails++;
            $error("FAIL wait_xy(%0d,%0d): observed timeout at x=%0d y=%0d expected arrival", x, y,
                   current_pixel_x, current_pixel_y);
        end
    endtask

    initial begin
        int n;
        int fs_snap;

        @(negedge clk);
        rst      = 1'b1;
        color_in = 8'hE0;
        cyc(3);
        check("rst_vga_clk", 32'(vga_clk), 32'h0);
        check("rst_x", 32'(current_pixel_x), 32'h0);
        check("rst_y", 32'(current_pixel_y), 32'h0);
        check("rst_hsync", 32'(vga_hsync), 32'h1);
        check("rst_vsync", 32'(vga_vsync), 32'h1);
        check("rst_blank_n", 32'(vga_blank_n), 32'h0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("sync_n", 32'(vga_sync_n), 32'h0);

        // Release: first edge raises vga_clk, second edge is the first tick.
        rst = 1'b0;
        cyc(1);
        check("rel_e1_vga_clk", 32'(vga_clk), 32'h1);
        check("rel_e1_x", 32'(current_pixel_x), 32'h0);
        check("rel_e1_blank_n", 32'(vga_blank_n), 32'h0);
        cyc(1);
        check("rel_e2_vga_clk", 32'(vga_clk), 32'h0);
        check("rel_e2_x", 32'(current_pixel_x), 32'h1);
        check("rel_e2_blank_n", 32'(vga_blank_n), 32'h1);
        check("rgb_E0", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        color_in = 8'h7B;
        cyc(1);
        check("e3_x_hold", 32'(current_pixel_x), 32'h1);
        check("e3_rgb_hold", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        cyc(1);
        check("e4_x", 32'(current_pixel_x), 32'h2);
        check("rgb_7B", 32'({vga_r, vga_g, vga_b}), 32'h6DDBFF);
        color_in = 8'hFC;
        cyc(2);
        check("e6_x", 32'(current_pixel_x), 32'h3);
        check("rgb_FC", 32'({vga_r, vga_g, vga_b}), 32'hFFFF00);

        // End of visible line, then blanking forces RGB to zero.
        color_in = 8'hFF;
        wait_xy(7, 0);
        cyc(2);
        check("x7_blank_n", 32'(vga_blank_n), 32'h1);
        check("x7_rgb_FF", 32'({vga_r, vga_g, vga_b}), 32'hFFFFFF);
        cyc(2);
        check("x8_blank_n", 32'(vga_blank_n), 32'h0);
        check("x8_rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'h0);

        // Horizontal sync window h=10..12, one tick late on the pin.
        wait_xy(10, 0);
        check("hs_before", 32'(vga_hsync), 32'h1);
        cyc(2);
        check("hs_start", 32'(vga_hsync), 32'h0);
        wait_xy(12, 0);
        check("hs_mid", 32'(vga_hsync), 32'h0);
        cyc(2);
        check("hs_last", 32'(vga_hsync), 32'h0);
        cyc(2);
        check("hs_end", 32'(vga_hsync), 32'h1);
        check("line_end_x", 32'(current_pixel_x), 32'd14);
        cyc(2);
        check("wrap_x", 32'(current_pixel_x), 32'h0);
        check("wrap_y", 32'(current_pixel_y), 32'h1);

        // Vertical sync lines 5..6 and vertical blanking.
        wait_xy(0, 5);
        check("vs_before", 32'(vga_vsync), 32'h1);
        cyc(2);
        check("vs_start", 32'(vga_vsync), 32'h0);
        check("vblank_blank_n", 32'(vga_blank_n), 32'h0);
        check("vblank_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        wait_xy(14, 6);
        check("vs_mid", 32'(vga_vsync), 32'h0);
        cyc(2);
        check("vs_last", 32'(vga_vsync), 32'h0);
        cyc(2);
        check("vs_end", 32'(vga_vsync), 32'h1);
        check("no_fs_first_frame", 32'(fs_seen), 32'h0);

        // Frame wrap and frame_start pulse period (15*8 ticks = 240 clk).
        wait_xy(14, 7);
        check("fs_before_wrap", 32'(frame_start), 32'h0);
        cyc(2);
        check("frame_wrap_x", 32'(current_pixel_x), 32'h0);
        check("frame_wrap_y", 32'(current_pixel_y), 32'h0);
        check("fs_pulse", 32'(frame_start), 32'h1);
        cyc(1);
        check("fs_one_clk", 32'(frame_start), 32'h0);
        n = 1;
        while (frame_start !== 1'b1 && n < 400) begin
            cyc(1);
            n++;
        end
        check("fs_period", 32'(n), 32'd240);

        // Mid-frame reset while visible and vga_clk high.
        wait_xy(6, 2);
        cyc(1);
        check("pre_rst_vga_clk", 32'(vga_clk), 32'h1);
        check("pre_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFFFFFF);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_x", 32'(current_pixel_x), 32'h0);
        check("mid_rst_y", 32'(current_pixel_y), 32'h0);
        check("mid_rst_vga_clk", 32'(vga_clk), 32'h0);
        check("mid_rst_blank_n", 32'(vga_blank_n), 32'h0);
        check("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        check("mid_rst_hsync", 32'(vga_hsync), 32'h1);
        check("mid_rst_vsync", 32'(vga_vsync), 32'h1);
        cyc(2);
        rst = 1'b0;
        fs_snap = fs_seen;
        cyc(2);
        check("restart_x", 32'(current_pixel_x), 32'h1);
        check("restart_y", 32'(current_pixel_y), 32'h0);
        wait_xy(14, 7);
        check("no_fs_after_rst", 32'(fs_seen - fs_snap), 32'h0);
        cyc(2);
        check("fs_after_rst_wrap", 32'(frame_start), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
